// File: rtl/aes_word_frontend.sv
// Word-serial key/plaintext loader, start strobe and cipher read-back for the AES-128 core.
// Optional: define AES_FE_KEY_WIPE_EN to clear the key on every cipher capture.
module aes_word_frontend #(
  parameter int unsigned CORE_LATENCY = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic         wr_sel,
  input  logic [31:0]  wr_data,
  output logic [127:0] core_secret,
  output logic [127:0] core_plaintext,
  output logic         core_start,
  input  logic [127:0] core_cipher,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [31:0]  rd_data,
  output logic         busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          key_idx;
  logic [1:0]          key_idx_nxt;
  logic                key_loaded;
  logic                key_loaded_nxt;
  logic [CNT_W-1:0]    data_cnt;
  logic [CNT_W-1:0]    data_cnt_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [1:0]          rd_idx;
  logic [BLK_W-1:0]    cipher_buf;
  logic                wr_fire;
  logic                key_wr;
  logic                data_wr;
  logic                rd_fire;
  logic                capture;
  logic                enter_run;
  logic [1:0]          key_slot;

  // Big-endian word insert: slot 0 is bits [127:96].
  function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0] blk,
                                                input logic [1:0] idx,
                                                input logic [WORD_W-1:0] w);
    logic [BLK_W-1:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  assign wr_ready  = (state == IDLE) && !reset;
  assign wr_fire   = wr_valid && wr_ready;
  assign key_wr    = wr_fire && !wr_sel;
  assign data_wr   = wr_fire && wr_sel && (data_cnt != CNT_W'(4));
  assign key_slot  = key_loaded ? 2'd0 : key_idx;
  assign rd_fire   = rd_valid && rd_ready;
  assign capture   = (state == RUN) && (wait_cnt == '0);
  assign enter_run = (state == IDLE) && (state_nxt == RUN);

  // Next-state and counter bookkeeping.
  always_comb begin
    state_nxt      = state;
    key_idx_nxt    = key_idx;
    key_loaded_nxt = key_loaded;
    data_cnt_nxt   = data_cnt;

    if (key_wr) begin
      if (key_loaded) begin
        key_idx_nxt    = 2'd1;
        key_loaded_nxt = 1'b0;
      end else begin
        key_idx_nxt = key_idx + 2'd1;
        if (key_idx == 2'd3) key_loaded_nxt = 1'b1;
      end
    end
    if (data_wr) data_cnt_nxt = data_cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        if (key_loaded_nxt && (data_cnt_nxt == CNT_W'(4))) state_nxt = RUN;
      end
      RUN: begin
        if (capture) begin
          state_nxt = OUT;
`ifdef AES_FE_KEY_WIPE_EN
          key_idx_nxt    = 2'd0;
          key_loaded_nxt = 1'b0;
`endif
        end
      end
      OUT: begin
        if (rd_fire && (rd_idx == 2'd3)) begin
          state_nxt    = IDLE;
          data_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers and registered strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_idx        <= '0;
      key_loaded     <= 1'b0;
      data_cnt       <= '0;
      wait_cnt       <= '0;
      rd_idx         <= '0;
      cipher_buf     <= '0;
      core_secret    <= '0;
      core_plaintext <= '0;
      core_start     <= 1'b0;
      rd_valid       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      key_idx    <= key_idx_nxt;
      key_loaded <= key_loaded_nxt;
      data_cnt   <= data_cnt_nxt;
      if (key_wr)  core_secret    <= put_word(core_secret, key_slot, wr_data);
      if (data_wr) core_plaintext <= put_word(core_plaintext, data_cnt[1:0], wr_data);
      if (enter_run)           wait_cnt <= WAIT_W'(CORE_LATENCY - 1);
      else if (state == RUN)   wait_cnt <= wait_cnt - WAIT_W'(1);
      if (capture) begin
        cipher_buf <= core_cipher;
`ifdef AES_FE_KEY_WIPE_EN
        core_secret <= '0;
`endif
      end
      if (rd_fire) rd_idx <= rd_idx + 2'd1;
      core_start <= enter_run;
      rd_valid   <= (state_nxt == OUT);
      busy       <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    rd_data = cipher_buf[127:96];
    case (rd_idx)
      2'd1:    rd_data = cipher_buf[95:64];
      2'd2:    rd_data = cipher_buf[63:32];
      2'd3:    rd_data = cipher_buf[31:0];
      default: rd_data = cipher_buf[127:96];
    endcase
  end

endmodule

// File: tb/tb_aes_word_frontend.sv
// Directed bench for aes_word_frontend: word table with per-write start checks, plus
// read-back, reset and CORE_LATENCY=1 sequences against a bench-side core model.
module tb_aes_word_frontend;

  localparam int unsigned LAT = 12;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2      = 128'h11111111222222223333333344444444;
  localparam logic [127:0] JUNK     = 128'hdeadbeef_00000000_00000000_00000000;
  localparam logic [127:0] GARBAGE  = {4{32'hbad0_f00d}};

  localparam int A_NONE = 0, A_READ = 1, A_TOGGLE = 2, A_RST_RUN = 3, A_RST_OUT = 4;

  typedef struct {
    logic         sel;
    logic [31:0]  data;
    logic         exp_start;
    int           act;
    logic [127:0] exp_ct;
  } vec_t;

  logic         clock, reset;
  logic         wr_valid, wr_ready, wr_sel;
  logic [31:0]  wr_data;
  logic [127:0] core_secret, core_plaintext, core_cipher;
  logic         core_start, rd_valid, rd_ready, busy;
  logic [31:0]  rd_data;

  logic         wr_valid1, wr_ready1, wr_sel1;
  logic [31:0]  wr_data1;
  logic [127:0] core_secret1, core_plaintext1, core_cipher1;
  logic         core_start1, rd_valid1, rd_ready1, busy1;
  logic [31:0]  rd_data1;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int start_mark = 0;
  int age = 0;
  vec_t tbl[$];

  // Stand-in core: known FIPS answer, otherwise an arbitrary mix of key and plaintext.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]} ^ {4{32'h5a5a_c3c3}};
  endfunction

  // Cipher is only valid in the single cycle LAT-1 after the start cycle.
  always @(posedge clock) begin
    if (core_start) start_cnt <= start_cnt + 1;
    if (core_start) age <= 1;
    else if (age != 0 && age < 1000) age <= age + 1;
  end
  assign core_cipher  = (age == int'(LAT) - 1) ? core_fn(core_secret, core_plaintext) : GARBAGE;
  assign core_cipher1 = core_start1 ? core_fn(core_secret1, core_plaintext1) : GARBAGE;

  aes_word_frontend #(.CORE_LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
    .core_secret(core_secret), .core_plaintext(core_plaintext), .core_start(core_start),
    .core_cipher(core_cipher),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .busy(busy)
  );

  aes_word_frontend #(.CORE_LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_sel(wr_sel1), .wr_data(wr_data1),
    .core_secret(core_secret1), .core_plaintext(core_plaintext1), .core_start(core_start1),
    .core_cipher(core_cipher1),
    .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rd_data(rd_data1), .busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wr1(input logic sel, input logic [31:0] d);
    wr_valid1 = 1'b1;
    wr_sel1   = sel;
    wr_data1  = d;
    step();
    wr_valid1 = 1'b0;
  endtask

  task automatic add_grp(input logic sel, input logic [127:0] blk, input int n0, input int n1,
                         input logic st, input int act, input logic [127:0] ct);
    for (int i = n0; i <= n1; i++) begin
      vec_t v;
      v.sel       = sel;
      v.data      = blk[127-32*i -: 32];
      v.exp_start = (i == n1) ? st : 1'b0;
      v.act       = (i == n1) ? act : A_NONE;
      v.exp_ct    = ct;
      tbl.push_back(v);
    end
  endtask

  // Reset is already high: outputs must be cleared before any edge, then release.
  task automatic check_reset_release(input string tag);
    #1;
    chk({tag, "_ctl"}, 128'({wr_ready, core_start, rd_valid, busy}), 128'(0));
    chk({tag, "_rd_data"}, 128'(rd_data), 128'(0));
    chk({tag, "_secret"}, core_secret, 128'(0));
    chk({tag, "_plain"}, core_plaintext, 128'(0));
    step();
    reset = 1'b0;
    #1;
    chk({tag, "_wr_ready_rel"}, 128'({wr_ready, busy}), 128'(2'b10));
  endtask

  task automatic wait_rd(input string tag);
    int n = 0;
    while (!rd_valid && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 128'(n + 1), 128'(LAT + 1));
  endtask

  task automatic read_block(input string tag, input logic [127:0] ct, input bit toggle,
                            input int nwords);
    int got = 0;
    int cyc = 0;
    while (got < nwords && cyc < 64) begin
      rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rd_valid && rd_ready) begin
        chk($sformatf("%s_word%0d", tag, got), 128'(rd_data), 128'(ct[127-32*got -: 32]));
        got++;
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    chk({tag, "_words"}, 128'(got), 128'(nwords));
    if (nwords == 4) begin
      if (!toggle) chk({tag, "_consecutive"}, 128'(cyc), 128'(4));
      chk({tag, "_back_to_back"}, 128'({wr_ready, busy, rd_valid}), 128'(3'b100));
    end
  endtask

  task automatic start_once(input string tag);
    chk({tag, "_start_once"}, 128'(start_cnt - start_mark), 128'(1));
    start_mark = start_cnt;
  endtask

  initial begin
    logic [127:0] ct2;
    logic [127:0] kw;
    ct2 = core_fn(FIPS_KEY, PT2);

    // Plaintext before key.
    add_grp(1'b1, FIPS_PT, 0, 3, 1'b0, A_NONE, '0);
    add_grp(1'b0, FIPS_KEY, 0, 3, 1'b1, A_READ, FIPS_CT);
    // Second block reusing the key, read with rd_ready toggling.
`ifdef AES_FE_KEY_WIPE_EN
    add_grp(1'b1, PT2, 0, 3, 1'b0, A_NONE, '0);
    add_grp(1'b0, FIPS_KEY, 0, 3, 1'b1, A_TOGGLE, ct2);
`else
    add_grp(1'b1, PT2, 0, 3, 1'b1, A_TOGGLE, ct2);
`endif
    // Key restart, data overrun, then the remaining three key words.
    add_grp(1'b0, FIPS_KEY, 0, 0, 1'b0, A_NONE, '0);
    add_grp(1'b1, FIPS_PT, 0, 3, 1'b0, A_NONE, '0);
    add_grp(1'b1, JUNK, 0, 0, 1'b0, A_NONE, '0);
    add_grp(1'b0, FIPS_KEY, 1, 3, 1'b1, A_READ, FIPS_CT);
    // Reset during RUN.
    add_grp(1'b0, FIPS_KEY, 0, 3, 1'b0, A_NONE, '0);
    add_grp(1'b1, FIPS_PT, 0, 3, 1'b1, A_RST_RUN, '0);
    // Key-first FIPS vector, reset after two reads.
    add_grp(1'b0, FIPS_KEY, 0, 3, 1'b0, A_NONE, '0);
    add_grp(1'b1, FIPS_PT, 0, 3, 1'b1, A_RST_OUT, FIPS_CT);
    // Full reload after reset.
    add_grp(1'b1, FIPS_PT, 0, 3, 1'b0, A_NONE, '0);
    add_grp(1'b0, FIPS_KEY, 0, 3, 1'b1, A_READ, FIPS_CT);

    reset = 1'b1;
    wr_valid = 1'b0; wr_sel = 1'b0; wr_data = '0; rd_ready = 1'b0;
    wr_valid1 = 1'b0; wr_sel1 = 1'b0; wr_data1 = '0; rd_ready1 = 1'b0;
    #1;
    check_reset_release("por");

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      wr(tbl[i].sel, tbl[i].data);
      chk({tag, "_start"}, 128'(core_start), 128'(tbl[i].exp_start));
      case (tbl[i].act)
        A_READ: begin
          wait_rd(tag);
          read_block(tag, tbl[i].exp_ct, 1'b0, 4);
          start_once(tag);
        end
        A_TOGGLE: begin
          wait_rd(tag);
          read_block(tag, tbl[i].exp_ct, 1'b1, 4);
          start_once(tag);
        end
        A_RST_RUN: begin
          repeat (4) step();
          chk({tag, "_mid_run"}, 128'({busy, rd_valid, wr_ready}), 128'(3'b100));
          reset = 1'b1;
          check_reset_release({tag, "_rst_run"});
          start_once(tag);
        end
        A_RST_OUT: begin
          wait_rd(tag);
          read_block(tag, tbl[i].exp_ct, 1'b0, 2);
          reset = 1'b1;
          check_reset_release({tag, "_rst_out"});
          start_once(tag);
        end
        default: ;
      endcase
    end

    // CORE_LATENCY=1: capture on the start cycle's edge.
    kw = FIPS_KEY;
    for (int i = 0; i < 4; i++) wr1(1'b0, kw[127-32*i -: 32]);
    kw = FIPS_PT;
    for (int i = 0; i < 4; i++) wr1(1'b1, kw[127-32*i -: 32]);
    chk("lat1_start", 128'({core_start1, rd_valid1}), 128'(2'b10));
    step();
    chk("lat1_rd_valid", 128'({core_start1, rd_valid1, busy1}), 128'(3'b011));
    rd_ready1 = 1'b1;
    kw = FIPS_CT;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lat1_word%0d", i), 128'(rd_data1), 128'(kw[127-32*i -: 32]));
      step();
    end
    rd_ready1 = 1'b0;
    chk("lat1_done", 128'({rd_valid1, wr_ready1}), 128'(2'b01));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
